// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    // Number of anti-diagonals in an R x C grid (length of the init wavefront line).
    function automatic int diag_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Parallel-tap register delay line: tap d is the input delayed by d cycles, tap 0 is the input itself.
module skew_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       din,
    output logic [DEPTH*W-1:0] taps
);

    assign taps[W-1:0] = din;

    for (genvar d = 1; d < DEPTH; d++) begin : g_stage
        logic [W-1:0] q_r;

        // one register stage per extra cycle of skew
        always_ff @(posedge clk) begin
            if (rst) begin
                q_r <= {W{1'b0}};
            end else begin
                q_r <= taps[(d-1)*W +: W];
            end
        end

        assign taps[d*W +: W] = q_r;
    end

endmodule

// File: rtl/systolic_sched.sv
// Job sequencer for an output-stationary systolic array: operand streaming, skew, init wavefront
// and result accounting.
module systolic_sched
    import systolic_pkg::*;
#(
    parameter int R      = 4,
    parameter int C      = 4,
    parameter int K_W    = 16,
    parameter int T_W    = 16,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [K_W-1:0]        k_len,
    input  logic [T_W-1:0]        num_tiles,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [R-1:0]          a_rd_en,
    output logic [R*ADDR_W-1:0]   a_rd_addr,
    output logic [C-1:0]          b_rd_en,
    output logic [C*ADDR_W-1:0]   b_rd_addr,
    output logic [R+C-1:0]        op_zero,
    output logic [R*C-1:0]        pe_init,
    input  logic                  res_valid,
    output logic                  res_discard
);

    localparam int DIAG_LEN = diag_len(R, C);
    localparam int CNT_W    = T_W + $clog2(R) + 1;
    localparam int SKW      = ADDR_W + 2;

    localparam logic [K_W-1:0]    K_ONE   = {{(K_W-1){1'b0}}, 1'b1};
    localparam logic [T_W-1:0]    T_ONE   = {{(T_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  R_CNT   = CNT_W'(R);
    localparam logic [K_W:0]      R_K     = (K_W+1)'(R);

    sched_state_t        state_r;
    logic [K_W-1:0]      k_len_r;
    logic [K_W-1:0]      k_r;
    logic [T_W-1:0]      num_tiles_r;
    logic [T_W-1:0]      tile_r;
    logic [CNT_W-1:0]    res_cnt_r;
    logic [CNT_W-1:0]    res_total_r;
    logic [ADDR_W-1:0]   base_addr_r;
    logic                base_en_r;
    logic                base_zero_r;
    logic                busy_r;
    logic                done_r;
    logic                cfg_err_r;
    logic [RD_LAT-1:0]   w0_dly_r;

    logic                cfg_bad_s;
    logic                accept_s;
    logic                last_k_s;
    logic                last_tile_s;
    logic                w0_s;
    logic                res_hit_s;
    logic [CNT_W-1:0]    res_cnt_nxt_s;
    logic [R*SKW-1:0]    a_taps_s;
    logic [C*SKW-1:0]    b_taps_s;
    logic [DIAG_LEN-1:0] diag_s;

    // start validation, wavefront source and result-count lookahead
    always_comb begin
        cfg_bad_s   = (k_len == {K_W{1'b0}}) || (num_tiles == {T_W{1'b0}}) || ({1'b0, k_len} < R_K);
        accept_s    = start && !cfg_bad_s && (state_r == IDLE) && !done_r;
        last_k_s    = (k_r == (k_len_r - K_ONE));
        last_tile_s = (tile_r == (num_tiles_r - T_ONE));
        w0_s        = base_en_r && ((k_r == {K_W{1'b0}}) || (state_r == FLUSH));
        res_hit_s   = res_valid && (state_r != IDLE);
        if (res_hit_s) begin
            res_cnt_nxt_s = res_cnt_r + CNT_ONE;
        end else begin
            res_cnt_nxt_s = res_cnt_r;
        end
    end

    // job FSM: counters, base read stream and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            k_len_r     <= {K_W{1'b0}};
            k_r         <= {K_W{1'b0}};
            num_tiles_r <= {T_W{1'b0}};
            tile_r      <= {T_W{1'b0}};
            res_cnt_r   <= {CNT_W{1'b0}};
            res_total_r <= {CNT_W{1'b0}};
            base_addr_r <= {ADDR_W{1'b0}};
            base_en_r   <= 1'b0;
            base_zero_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            cfg_err_r <= 1'b0;
            res_cnt_r <= res_cnt_nxt_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r     <= FEED;
                        busy_r      <= 1'b1;
                        k_len_r     <= k_len;
                        num_tiles_r <= num_tiles;
                        res_total_r <= (CNT_W'(num_tiles) + CNT_ONE) * R_CNT;
                        res_cnt_r   <= {CNT_W{1'b0}};
                        k_r         <= {K_W{1'b0}};
                        tile_r      <= {T_W{1'b0}};
                        base_addr_r <= {ADDR_W{1'b0}};
                        base_en_r   <= 1'b1;
                        base_zero_r <= 1'b0;
                    end else if (start && !done_r && cfg_bad_s) begin
                        cfg_err_r <= 1'b1;
                    end
                end
                FEED: begin
                    // address is tile*k_len + k, which advances by exactly one per read
                    if (last_k_s) begin
                        k_r <= {K_W{1'b0}};
                        if (last_tile_s) begin
                            state_r     <= FLUSH;
                            base_zero_r <= 1'b1;
                        end else begin
                            tile_r      <= tile_r + T_ONE;
                            base_addr_r <= base_addr_r + A_ONE;
                        end
                    end else begin
                        k_r         <= k_r + K_ONE;
                        base_addr_r <= base_addr_r + A_ONE;
                    end
                end
                FLUSH: begin
                    state_r     <= DRAIN;
                    base_en_r   <= 1'b0;
                    base_zero_r <= 1'b0;
                end
                DRAIN: begin
                    if (res_cnt_nxt_s == res_total_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // align the init wavefront with operand data returning from the buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            w0_dly_r <= {RD_LAT{1'b0}};
        end else begin
            w0_dly_r[0] <= w0_s;
            for (int d = 1; d < RD_LAT; d++) begin
                w0_dly_r[d] <= w0_dly_r[d-1];
            end
        end
    end

    skew_line #(.W(SKW), .DEPTH(R)) u_a_skew (
        .clk  (clk),
        .rst  (rst),
        .din  ({base_en_r, base_zero_r, base_addr_r}),
        .taps (a_taps_s)
    );

    skew_line #(.W(SKW), .DEPTH(C)) u_b_skew (
        .clk  (clk),
        .rst  (rst),
        .din  ({base_en_r, base_zero_r, base_addr_r}),
        .taps (b_taps_s)
    );

    skew_line #(.W(1), .DEPTH(DIAG_LEN)) u_diag (
        .clk  (clk),
        .rst  (rst),
        .din  (w0_dly_r[RD_LAT-1]),
        .taps (diag_s)
    );

    for (genvar i = 0; i < R; i++) begin : g_row
        assign a_rd_en[i]                    = a_taps_s[i*SKW + SKW - 1];
        assign op_zero[i]                    = a_taps_s[i*SKW + ADDR_W];
        assign a_rd_addr[i*ADDR_W +: ADDR_W] = a_taps_s[i*SKW +: ADDR_W];
    end

    for (genvar j = 0; j < C; j++) begin : g_col
        assign b_rd_en[j]                    = b_taps_s[j*SKW + SKW - 1];
        assign op_zero[R+j]                  = b_taps_s[j*SKW + ADDR_W];
        assign b_rd_addr[j*ADDR_W +: ADDR_W] = b_taps_s[j*SKW +: ADDR_W];
    end

    // PE(i,j) sits on anti-diagonal i+j
    for (genvar i = 0; i < R; i++) begin : g_init_row
        for (genvar j = 0; j < C; j++) begin : g_init_col
            assign pe_init[i*C + j] = diag_s[i + j];
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign cfg_err     = cfg_err_r;
    assign res_discard = res_hit_s && (res_cnt_r < R_CNT);

endmodule

// File: tb/tb_systolic_sched.sv
// Directed bench for systolic_sched with a behavioural 4x4 MAC grid closing the result loop.
module tb_systolic_sched;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, res_valid, busy, done, cfg_err, res_discard;
    logic [15:0]        k_len, num_tiles;
    logic [R-1:0]       a_rd_en;
    logic [R*AW-1:0]    a_rd_addr;
    logic [C-1:0]       b_rd_en;
    logic [C*AW-1:0]    b_rd_addr;
    logic [R+C-1:0]     op_zero;
    logic [R*C-1:0]     pe_init;

    logic               start_w, res_valid_w, busy_w, done_w, cfg_err_w, res_discard_w;
    logic [15:0]        k_len_w, num_tiles_w;
    logic [R-1:0]       a_rd_en_w;
    logic [R*4-1:0]     a_rd_addr_w;
    logic [C-1:0]       b_rd_en_w;
    logic [C*4-1:0]     b_rd_addr_w;
    logic [R+C-1:0]     op_zero_w;
    logic [R*C-1:0]     pe_init_w;

    systolic_sched dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .num_tiles(num_tiles),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
        .op_zero(op_zero), .pe_init(pe_init), .res_valid(res_valid), .res_discard(res_discard)
    );

    systolic_sched #(.ADDR_W(4)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .k_len(k_len_w), .num_tiles(num_tiles_w),
        .busy(busy_w), .done(done_w), .cfg_err(cfg_err_w),
        .a_rd_en(a_rd_en_w), .a_rd_addr(a_rd_addr_w), .b_rd_en(b_rd_en_w), .b_rd_addr(b_rd_addr_w),
        .op_zero(op_zero_w), .pe_init(pe_init_w), .res_valid(res_valid_w), .res_discard(res_discard_w)
    );

    int a_mem [R][64];
    int b_mem [C][64];
    int a_data [R];
    int b_data [C];
    int a_pe [R][C];
    int b_pe [R][C];
    int acc [R][C];
    int res_q [$];
    int res_data;
    int m_ain, m_bin;

    // behavioural grid: buffers with 1-cycle read, MAC PEs, column C-1 result chain
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < R; i++) begin
                a_data[i] <= 0;
                b_data[i] <= 0;
                for (int j = 0; j < C; j++) begin
                    a_pe[i][j] <= 0;
                    b_pe[i][j] <= 0;
                    acc[i][j]  <= 0;
                end
            end
            res_q.delete();
            res_valid <= 1'b0;
            res_data  <= 0;
        end else begin
            if (res_q.size() > 0) begin
                res_valid <= 1'b1;
                res_data  <= res_q.pop_front();
            end else begin
                res_valid <= 1'b0;
            end
            for (int i = 0; i < R; i++) begin
                for (int j = 0; j < C; j++) begin
                    m_ain = (j == 0) ? a_data[i] : a_pe[i][j-1];
                    m_bin = (i == 0) ? b_data[j] : b_pe[i-1][j];
                    if (pe_init[i*C+j]) begin
                        if (j == C-1) res_q.push_back(acc[i][j]);
                        acc[i][j] <= m_ain * m_bin;
                    end else begin
                        acc[i][j] <= acc[i][j] + m_ain * m_bin;
                    end
                    a_pe[i][j] <= m_ain;
                    b_pe[i][j] <= m_bin;
                end
                a_data[i] <= (a_rd_en[i] && !op_zero[i]) ? a_mem[i][a_rd_addr[i*AW +: 6]] : 0;
                b_data[i] <= (b_rd_en[i] && !op_zero[R+i]) ? b_mem[i][b_rd_addr[i*AW +: 6]] : 0;
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int n_disc;
    int kept [$];
    logic [31:0] busy_v, a0_v, z0_v, a3_v, b2_v, zc2_v, i0_v, i15_v, done_v, cfg_v;

    function automatic int gold(input int t, input int i, input int kl);
        int s = 0;
        for (int k = 0; k < kl; k++) s += a_mem[i][t*kl+k] * b_mem[C-1][t*kl+k];
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (res_valid) begin
            if (res_discard) n_disc++;
            else kept.push_back(res_data);
        end
    endtask

    task automatic check_kept(input string tag, input int tiles, input int kl);
        check({tag, "_discards"}, 64'(n_disc), 64'(R));
        check({tag, "_kept_count"}, 64'(kept.size()), 64'(tiles*R));
        for (int t = 0; t < tiles; t++) begin
            for (int i = 0; i < R; i++) begin
                check({tag, "_result"}, 64'((t*R+i < kept.size()) ? kept[t*R+i] : -1), 64'(gold(t, i, kl)));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < R; i++) begin
            for (int a = 0; a < 64; a++) begin
                a_mem[i][a] = (i*7 + a*3 + 1) % 13;
                b_mem[i][a] = (i*5 + a*2 + 3) % 11;
            end
        end
        rst = 1'b1; start = 1'b0; k_len = 16'd0; num_tiles = 16'd0;
        start_w = 1'b0; k_len_w = 16'd0; num_tiles_w = 16'd0; res_valid_w = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", 64'({busy, done, cfg_err, a_rd_en, b_rd_en, op_zero, pe_init, res_discard}), 64'd0);
        check("reset_addr", 64'(a_rd_addr | b_rd_addr), 64'd0);

        // basic job k_len=4, num_tiles=2, with a stray start mid-FEED and a start on the done cycle
        n_disc = 0; kept.delete();
        {busy_v, a0_v, z0_v, a3_v, b2_v, zc2_v, i0_v, i15_v, done_v, cfg_v} = '0;
        k_len = 16'd4; num_tiles = 16'd2; start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 3) begin start = 1'b1; k_len = 16'd5; num_tiles = 16'd1; end
            if (c == 4) start = 1'b0;
            if (c <= 19) begin
                busy_v[c] = busy;        a0_v[c] = a_rd_en[0];   z0_v[c] = op_zero[0];
                a3_v[c]   = a_rd_en[3];  b2_v[c] = b_rd_en[2];   zc2_v[c] = op_zero[R+2];
                i0_v[c]   = pe_init[0];  i15_v[c] = pe_init[15]; done_v[c] = done;
                cfg_v[c]  = cfg_err;
            end
            if (c <= 9) check("addr_row0", 64'(a_rd_addr[15:0]), 64'((c <= 8) ? c-1 : 7));
            if (c >= 4 && c <= 12) check("addr_row3", 64'(a_rd_addr[63:48]), 64'((c <= 11) ? c-4 : 7));
            if (c == 19) begin start = 1'b1; k_len = 16'd4; num_tiles = 16'd2; end
            if (c == 20) check("start_on_done_not_taken", 64'({busy, done}), 64'd0);
            if (c == 21) begin check("start_after_done_taken", 64'(busy), 64'd1); start = 1'b0; end
        end
        check("busy_trace",   64'(busy_v), 64'h7FFFE);
        check("a_en0_trace",  64'(a0_v),   64'h3FE);
        check("zero0_trace",  64'(z0_v),   64'h200);
        check("a_en3_trace",  64'(a3_v),   64'h1FF0);
        check("b_en2_trace",  64'(b2_v),   64'hFF8);
        check("zero_c2_trace", 64'(zc2_v), 64'h800);
        check("init0_trace",  64'(i0_v),   64'h444);
        check("init15_trace", 64'(i15_v),  64'h11100);
        check("done_trace",   64'(done_v), 64'h80000);
        check("cfg_err_quiet", 64'(cfg_v), 64'h0);
        check_kept("basic", 2, 4);

        // second job started at cycle 20 is reset at its cycle 5, then a fresh job from cycle 8
        for (int r = 2; r <= 5; r++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_mid_ctrl", 64'({busy, done, cfg_err, a_rd_en, b_rd_en, op_zero, pe_init, res_discard}), 64'd0);
        check("reset_mid_addr", 64'(a_rd_addr | b_rd_addr), 64'd0);
        n_disc = 0; kept.delete(); done_v = '0;
        tick(); done_v[7] = done;
        tick(); done_v[8] = done;
        k_len = 16'd5; num_tiles = 16'd1; start = 1'b1;
        for (int r = 9; r <= 31; r++) begin
            tick();
            if (r == 9) start = 1'b0;
            done_v[r] = done;
        end
        check("after_reset_done_trace", 64'(done_v), 64'h100_0000);
        check_kept("after_reset", 1, 5);

        // configuration errors
        k_len = 16'd3; num_tiles = 16'd2; start = 1'b1;
        tick(); start = 1'b0;
        check("cfg_klen_small", 64'({cfg_err, busy}), 64'h2);
        tick();
        check("cfg_klen_pulse", 64'({cfg_err, busy}), 64'h0);
        k_len = 16'd4; num_tiles = 16'd0; start = 1'b1;
        tick(); start = 1'b0;
        check("cfg_tiles_zero", 64'({cfg_err, busy}), 64'h2);
        tick();
        check("cfg_tiles_pulse", 64'({cfg_err, busy}), 64'h0);

        // address wrap on the 4-bit instance
        k_len_w = 16'd8; num_tiles_w = 16'd3; start_w = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 1) start_w = 1'b0;
            check("wrap_addr", 64'({a_rd_en_w[0], a_rd_addr_w[3:0]}), 64'({1'b1, 4'((c <= 24) ? c-1 : 7)}));
        end
        tick();
        check("wrap_drain_en", 64'(a_rd_en_w[0]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
